// File: rtl/fifo_flagged_if.sv
// rtl/fifo_flagged_if.sv - producer/consumer bundle for the flagged FIFO
interface fifo_flagged_if #(
  parameter int BUFFER_SIZE = 8,
  parameter int ITEM_SIZE   = 8
);
  localparam int CW = $clog2(BUFFER_SIZE + 1);

  logic                 write_en;
  logic                 read_en;
  logic                 clear_err;
  logic [ITEM_SIZE-1:0] data_in;
  logic [ITEM_SIZE-1:0] data_out;
  logic                 full;
  logic                 empty;
  logic                 almost_full;
  logic                 almost_empty;
  logic [CW-1:0]        count;
  logic                 overflow;
  logic                 underflow;

  modport master (
    output write_en, read_en, clear_err, data_in,
    input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  write_en, read_en, clear_err, data_in,
    output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_flagged.sv
// rtl/fifo_flagged.sv - synchronous FIFO with level flags, sticky errors and optional FWFT read
module fifo_flagged #(
  parameter int BUFFER_SIZE = 8,
  parameter int ITEM_SIZE   = 8,
  parameter int AF_LEVEL    = 6,
  parameter int AE_LEVEL    = 2,
  parameter bit FWFT        = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  fifo_flagged_if.slave bus
);
  localparam int AW = $clog2(BUFFER_SIZE);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(BUFFER_SIZE + 1);
  localparam logic [CW-1:0] AF_L = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_L = CW'(AE_LEVEL);

  logic [ITEM_SIZE-1:0] mem_q [BUFFER_SIZE];

  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [ITEM_SIZE-1:0] dout_q, dout_d;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;

  logic                 full_w, empty_w;
  logic                 wr_ok, rd_ok;
  logic [ITEM_SIZE-1:0] head_w;

  // Pointers carry one extra wrap bit so equal addresses can be told apart as full or empty
  assign full_w  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign empty_w = (wr_ptr_q == rd_ptr_q);
  assign head_w  = mem_q[rd_ptr_q[AW-1:0]];

  // A write into a full FIFO is still taken when a read frees a slot in the same cycle
  assign wr_ok = bus.write_en & (~full_w | bus.read_en);
  assign rd_ok = bus.read_en & ~empty_w;

  // Next-state for pointers, occupancy, registered read data and sticky error flags
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (rd_ok) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      dout_d   = head_w;
    end
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A fresh rejection in the clearing cycle keeps the flag set
    ovf_d = (bus.write_en & ~wr_ok) | (ovf_q & ~bus.clear_err);
    unf_d = (bus.read_en & ~rd_ok) | (unf_q & ~bus.clear_err);
  end

  // State registers; reset discards queued items by collapsing the pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage array is left unreset so it can map onto plain RAM
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= bus.data_in;
    end
  end

  // FWFT shows the head item combinationally; otherwise the popped item is held in a register
  assign bus.data_out     = FWFT ? (empty_w ? '0 : head_w) : dout_q;
  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (count_q >= AF_L);
  assign bus.almost_empty = (count_q <= AE_L);
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_fifo_flagged.sv
// tb/tb_fifo_flagged.sv - self-checking bench for fifo_flagged in registered and FWFT modes
module tb_fifo_flagged;
  localparam int N  = 8;
  localparam int W  = 8;
  localparam int AF = 6;
  localparam int AE = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fifo_flagged_if #(.BUFFER_SIZE(N), .ITEM_SIZE(W)) bus0 ();
  fifo_flagged_if #(.BUFFER_SIZE(N), .ITEM_SIZE(W)) bus1 ();

  fifo_flagged #(.BUFFER_SIZE(N), .ITEM_SIZE(W), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1'b0))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  fifo_flagged #(.BUFFER_SIZE(N), .ITEM_SIZE(W), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1'b1))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int checks = 0;
  int errors = 0;

  logic [W-1:0] mq[$];
  logic [W-1:0] m_dout0;
  bit           m_ovf, m_unf;

  typedef struct {
    bit           w;
    bit           r;
    bit           c;
    logic [W-1:0] din;
    logic [W-1:0] dout;
    int           cnt;
    bit           full;
    bit           empty;
    bit           ovf;
    bit           unf;
  } vec_t;

  vec_t tbl[$];
  logic [W-1:0] fill_vals [8] = '{8'd1, 8'd3, 8'd7, 8'd15, 8'd31, 8'd63, 8'd127, 8'd255};
  logic [W-1:0] exp_drain [8] = '{8'd15, 8'd31, 8'd63, 8'd127, 8'd255, 8'hAA, 8'hAA, 8'hAA};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input bit w, input bit r, input bit c, input logic [W-1:0] d);
    bus0.write_en = w; bus0.read_en = r; bus0.clear_err = c; bus0.data_in = d;
    bus1.write_en = w; bus1.read_en = r; bus1.clear_err = c; bus1.data_in = d;
  endtask

  // Reference: a plain queue, popped before pushing so a full FIFO can swap in one cycle
  task automatic model_edge(input bit w, input bit r, input bit c, input logic [W-1:0] d);
    int sz;
    bit rd_acc, wr_acc;
    sz     = mq.size();
    rd_acc = r && (sz > 0);
    wr_acc = w && ((sz < N) || r);
    if (rd_acc) m_dout0 = mq.pop_front();
    if (wr_acc) mq.push_back(d);
    m_ovf = (w && !wr_acc) || (m_ovf && !c);
    m_unf = (r && !rd_acc) || (m_unf && !c);
  endtask

  task automatic check_model();
    int sz;
    logic [5:0] ef;
    logic [W-1:0] head;
    sz   = mq.size();
    ef   = {sz == N, sz == 0, sz >= AF, sz <= AE, m_ovf, m_unf};
    head = (sz > 0) ? mq[0] : '0;
    chk("count0", 32'(bus0.count), 32'(sz));
    chk("flags0", {26'd0, bus0.full, bus0.empty, bus0.almost_full, bus0.almost_empty,
                   bus0.overflow, bus0.underflow}, {26'd0, ef});
    chk("dout0", 32'(bus0.data_out), 32'(m_dout0));
    chk("count1", 32'(bus1.count), 32'(sz));
    chk("flags1", {26'd0, bus1.full, bus1.empty, bus1.almost_full, bus1.almost_empty,
                   bus1.overflow, bus1.underflow}, {26'd0, ef});
    chk("dout1_fwft", 32'(bus1.data_out), 32'(head));
  endtask

  task automatic apply(input bit w, input bit r, input bit c, input logic [W-1:0] d);
    set_in(w, r, c, d);
    @(posedge clk);
    model_edge(w, r, c, d);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, '0);
    #2;
    mq.delete();
    m_dout0 = '0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    chk("rst_count", 32'(bus0.count), 32'd0);
    chk("rst_empty_ae", {30'd0, bus0.empty, bus0.almost_empty}, 32'd3);
    check_model();
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, '0);
    #1;
    do_reset();

    // Fill, overflow, drain, underflow and clear as constant vectors
    for (int i = 0; i < 8; i++)
      tbl.push_back('{1'b1, 1'b0, 1'b0, fill_vals[i], 8'd0, i + 1, i == 7, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 8'd17, 8'd0, 8, 1'b1, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 8'd21, 8'd0, 8, 1'b1, 1'b0, 1'b1, 1'b0});
    for (int i = 0; i < 8; i++)
      tbl.push_back('{1'b0, 1'b1, 1'b0, 8'd0, fill_vals[i], 7 - i, 1'b0, i == 7, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 8'd0, 8'd255, 0, 1'b0, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 8'd0, 8'd255, 0, 1'b0, 1'b1, 1'b0, 1'b0});

    foreach (tbl[k]) begin
      apply(tbl[k].w, tbl[k].r, tbl[k].c, tbl[k].din);
      chk($sformatf("tbl%0d_dout", k), 32'(bus0.data_out), 32'(tbl[k].dout));
      chk($sformatf("tbl%0d_count", k), 32'(bus0.count), 32'(tbl[k].cnt));
      chk($sformatf("tbl%0d_flags", k), {28'd0, bus0.full, bus0.empty, bus0.overflow, bus0.underflow},
          {28'd0, tbl[k].full, tbl[k].empty, tbl[k].ovf, tbl[k].unf});
    end

    // Simultaneous read and write while full keeps occupancy at the top
    do_reset();
    for (int i = 0; i < 8; i++) apply(1'b1, 1'b0, 1'b0, fill_vals[i]);
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 1'b1, 1'b0, 8'hAA);
      chk("swap_count", 32'(bus0.count), 32'd8);
      chk("swap_full_ovf", {30'd0, bus0.full, bus0.overflow}, 32'd2);
      chk("swap_dout", 32'(bus0.data_out), 32'(fill_vals[i]));
    end
    for (int i = 0; i < 8; i++) begin
      apply(1'b0, 1'b1, 1'b0, 8'd0);
      chk("swap_drain", 32'(bus0.data_out), 32'(exp_drain[i]));
    end
    chk("swap_empty", 32'(bus0.empty), 32'd1);

    // Threshold edges
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      apply(1'b1, 1'b0, 1'b0, 8'(i));
      if (i == 5) chk("af_at5", 32'(bus0.almost_full), 32'd0);
      if (i == 6) chk("af_at6", 32'(bus0.almost_full), 32'd1);
    end
    for (int i = 5; i >= 2; i--) begin
      apply(1'b0, 1'b1, 1'b0, 8'd0);
      if (i == 3) chk("ae_at3", 32'(bus0.almost_empty), 32'd0);
      if (i == 2) chk("ae_at2", 32'(bus0.almost_empty), 32'd1);
    end

    // FWFT shows a new head without a read; registered mode does not
    do_reset();
    apply(1'b1, 1'b0, 1'b0, 8'h5A);
    chk("fwft_head", 32'(bus1.data_out), 32'h5A);
    chk("reg_no_read", 32'(bus0.data_out), 32'h00);

    // Random traffic in alternating fill/drain bursts, wrapping many times, with one reset mid-stream
    for (int i = 0; i < 400; i++) begin
      bit w, r, c;
      bit fill_phase;
      fill_phase = ((i / 24) % 2) == 0;
      w = $urandom_range(0, 99) < (fill_phase ? 75 : 35);
      r = $urandom_range(0, 99) < (fill_phase ? 35 : 75);
      c = ($urandom_range(0, 15) == 0);
      apply(w, r, c, 8'($urandom));
      if (i == 210) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
